mem_access_aligner: RTL and testbench

- Parametrised, sequential successor to the combinational store-lane replicator.
- Sits between the CPU load/store stage and the data-memory bus.
- Turns a byte/half/word/dword request at any address into bus beats: sizes sub-word data and generates the byte-select mask.
- Splits misaligned, lane-crossing accesses into two beats; reassembles and sign/zero-extends load data.

---
 rtl/mem_access_aligner_if.sv | 45 ++++
 rtl/mem_access_aligner.sv | 210 +++++++++++++++++++++
 tb/tb_mem_access_aligner.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_aligner_if.sv
// Request, data-bus and response signals of the memory access aligner.
// master = CPU/bus environment side, slave = the aligner itself.
interface mem_access_aligner_if #(
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned N = DATA_W / 8;

    // CPU request
    logic              ReqValid;
    logic              ReqReady;
    logic              ReqWrite;
    logic [1:0]        ReqSize;
    logic              ReqSigned;
    logic [31:0]       ReqAddr;
    logic [DATA_W-1:0] ReqData;

    // Data-memory bus
    logic              BusValid;
    logic              BusReady;
    logic              BusWrite;
    logic [31:0]       BusAddr;
    logic [N-1:0]      BusSel;
    logic [DATA_W-1:0] BusData;
    logic              BusRdValid;
    logic [DATA_W-1:0] BusRdData;

    // Completion
    logic              RspValid;
    logic [DATA_W-1:0] RspData;
    logic              RspErr;

    modport master (
        output ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqData,
        output BusReady, BusRdValid, BusRdData,
        input  ReqReady, BusValid, BusWrite, BusAddr, BusSel, BusData,
        input  RspValid, RspData, RspErr
    );

    modport slave (
        input  ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqData,
        input  BusReady, BusRdValid, BusRdData,
        output ReqReady, BusValid, BusWrite, BusAddr, BusSel, BusData,
        output RspValid, RspData, RspErr
    );
endinterface

// File: rtl/mem_access_aligner.sv
// Memory access aligner: turns byte/half/word/dword CPU requests at any
// address into one or two lane-aligned bus beats, and reassembles and
// sign/zero-extends the returned load data.
module mem_access_aligner #(
    parameter int unsigned DATA_W         = 32,
    parameter bit          ALLOW_MISALIGN = 1'b1
) (
    input logic                 clk,
    input logic                 rst_n,
    mem_access_aligner_if.slave mif
);
    localparam int unsigned N     = DATA_W / 8;
    localparam int unsigned OFS_W = $clog2(N);
    localparam int unsigned SEL_W = 2 * N;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        BEAT0 = 3'd1,
        WAIT0 = 3'd2,
        BEAT1 = 3'd3,
        WAIT1 = 3'd4,
        RESP  = 3'd5
    } state_t;

    state_t            state_q;
    logic              write_q;
    logic              signed_q;
    logic              split_q;
    logic [1:0]        size_q;
    logic [OFS_W-1:0]  off_q;
    logic [N-1:0]      sel1_q;
    logic [DATA_W-1:0] rd0_q;

    logic              bus_valid_q;
    logic              bus_write_q;
    logic [31:0]       bus_addr_q;
    logic [N-1:0]      bus_sel_q;
    logic [DATA_W-1:0] bus_data_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_err_q;

    // Request decode: size, offset, error, split and lane placement
    int unsigned       req_bytes_c;
    int unsigned       req_off_c;
    int unsigned       lane_c;
    logic              req_aligned_c;
    logic              req_err_c;
    logic              req_split_c;
    logic [SEL_W-1:0]  req_sel_wide_c;
    logic [DATA_W-1:0] req_lanes_c;

    // Load reassembly across the two beats, then mask and extend
    logic [2*DATA_W-1:0] rd_pair_c;
    logic [DATA_W-1:0]   rd_shift_c;
    logic [DATA_W-1:0]   rd_mask_c;
    logic [DATA_W-1:0]   rd_result_c;
    int unsigned         rsp_bytes_c;

    assign mif.ReqReady = (state_q == IDLE) && rst_n;
    assign mif.BusValid = bus_valid_q;
    assign mif.BusWrite = bus_write_q;
    assign mif.BusAddr  = bus_addr_q;
    assign mif.BusSel   = bus_sel_q;
    assign mif.BusData  = bus_data_q;
    assign mif.RspValid = rsp_valid_q;
    assign mif.RspData  = rsp_data_q;
    assign mif.RspErr   = rsp_err_q;

    // Decode the incoming request; aligned data is replicated, misaligned data rotated
    always_comb begin
        req_bytes_c    = 32'd1 << mif.ReqSize;
        req_off_c      = 32'(mif.ReqAddr[OFS_W-1:0]);
        req_aligned_c  = ((req_off_c & (req_bytes_c - 32'd1)) == 32'd0);
        req_err_c      = ((mif.ReqSize == 2'd3) && (DATA_W == 32)) ||
                         (!ALLOW_MISALIGN && !req_aligned_c);
        req_split_c    = ((req_off_c + req_bytes_c) > N);
        req_sel_wide_c = SEL_W'(((32'd1 << req_bytes_c) - 32'd1) << req_off_c);
        req_lanes_c    = '0;
        lane_c         = 0;
        for (int unsigned i = 0; i < N; i++) begin
            lane_c = req_aligned_c ? (i & (req_bytes_c - 32'd1))
                                   : ((i + N - req_off_c) & (N - 32'd1));
            if (lane_c < req_bytes_c) begin
                req_lanes_c[8*i +: 8] = mif.ReqData[8*lane_c +: 8];
            end
        end
    end

    // Shift the beat pair down by the offset, keep S bytes, extend the rest
    always_comb begin
        rd_pair_c   = {mif.BusRdData, (state_q == WAIT0) ? mif.BusRdData : rd0_q};
        rd_shift_c  = DATA_W'(rd_pair_c >> (8 * 32'(off_q)));
        rsp_bytes_c = 32'd1 << size_q;
        rd_mask_c   = '0;
        for (int unsigned b = 0; b < N; b++) begin
            rd_mask_c[8*b +: 8] = (b < rsp_bytes_c) ? 8'hFF : 8'h00;
        end
        rd_result_c = rd_shift_c & rd_mask_c;
        if (signed_q && rd_shift_c[8*rsp_bytes_c - 1]) begin
            rd_result_c = rd_result_c | ~rd_mask_c;
        end
    end

    // Access sequencer with registered bus and response outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            signed_q    <= 1'b0;
            split_q     <= 1'b0;
            size_q      <= 2'd0;
            off_q       <= '0;
            sel1_q      <= '0;
            rd0_q       <= '0;
            bus_valid_q <= 1'b0;
            bus_write_q <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_sel_q   <= '0;
            bus_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mif.ReqValid) begin
                        write_q  <= mif.ReqWrite;
                        signed_q <= mif.ReqSigned;
                        size_q   <= mif.ReqSize;
                        off_q    <= mif.ReqAddr[OFS_W-1:0];
                        split_q  <= req_split_c;
                        sel1_q   <= req_sel_wide_c[SEL_W-1:N];
                        if (req_err_c) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_data_q  <= '0;
                        end else begin
                            state_q     <= BEAT0;
                            bus_valid_q <= 1'b1;
                            bus_write_q <= mif.ReqWrite;
                            bus_addr_q  <= {mif.ReqAddr[31:OFS_W], OFS_W'(0)};
                            bus_sel_q   <= req_sel_wide_c[N-1:0];
                            bus_data_q  <= req_lanes_c;
                        end
                    end
                end
                BEAT0: begin
                    if (mif.BusReady) begin
                        bus_valid_q <= 1'b0;
                        if (!write_q) begin
                            state_q <= WAIT0;
                        end else if (split_q) begin
                            state_q     <= BEAT1;
                            bus_valid_q <= 1'b1;
                            bus_addr_q  <= bus_addr_q + 32'(N);
                            bus_sel_q   <= sel1_q;
                        end else begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                        end
                    end
                end
                WAIT0: begin
                    if (mif.BusRdValid) begin
                        rd0_q <= mif.BusRdData;
                        if (split_q) begin
                            state_q     <= BEAT1;
                            bus_valid_q <= 1'b1;
                            bus_addr_q  <= bus_addr_q + 32'(N);
                            bus_sel_q   <= sel1_q;
                        end else begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= rd_result_c;
                        end
                    end
                end
                BEAT1: begin
                    if (mif.BusReady) begin
                        bus_valid_q <= 1'b0;
                        if (write_q) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                        end else begin
                            state_q <= WAIT1;
                        end
                    end
                end
                WAIT1: begin
                    if (mif.BusRdValid) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= rd_result_c;
                    end
                end
                RESP: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    rsp_data_q  <= '0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_aligner.sv
// Directed bench for mem_access_aligner: one instance with misaligned
// accesses enabled, one with them disabled, both 32 bits wide.
module tb_mem_access_aligner;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    mem_access_aligner_if #(.DATA_W(32)) ia ();
    mem_access_aligner_if #(.DATA_W(32)) im ();

    mem_access_aligner #(.DATA_W(32), .ALLOW_MISALIGN(1'b1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .mif   (ia.slave)
    );

    mem_access_aligner #(.DATA_W(32), .ALLOW_MISALIGN(1'b0)) dut_m (
        .clk   (clk),
        .rst_n (rst_n),
        .mif   (im.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_a(input logic wr, input logic [1:0] sz, input logic sg,
                           input logic [31:0] addr, input logic [31:0] data);
        ia.ReqValid  = 1'b1;
        ia.ReqWrite  = wr;
        ia.ReqSize   = sz;
        ia.ReqSigned = sg;
        ia.ReqAddr   = addr;
        ia.ReqData   = data;
        chk("a_req_ready", 64'(ia.ReqReady), 64'd1);
        tick();
        ia.ReqValid = 1'b0;
    endtask

    task automatic issue_m(input logic wr, input logic [1:0] sz, input logic sg,
                           input logic [31:0] addr, input logic [31:0] data);
        im.ReqValid  = 1'b1;
        im.ReqWrite  = wr;
        im.ReqSize   = sz;
        im.ReqSigned = sg;
        im.ReqAddr   = addr;
        im.ReqData   = data;
        chk("m_req_ready", 64'(im.ReqReady), 64'd1);
        tick();
        im.ReqValid = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        ia.ReqValid = 1'b0; ia.ReqWrite = 1'b0; ia.ReqSize = 2'd0; ia.ReqSigned = 1'b0;
        ia.ReqAddr = 32'd0; ia.ReqData = 32'd0;
        ia.BusReady = 1'b1; ia.BusRdValid = 1'b0; ia.BusRdData = 32'd0;
        im.ReqValid = 1'b0; im.ReqWrite = 1'b0; im.ReqSize = 2'd0; im.ReqSigned = 1'b0;
        im.ReqAddr = 32'd0; im.ReqData = 32'd0;
        im.BusReady = 1'b1; im.BusRdValid = 1'b0; im.BusRdData = 32'd0;

        // Reset state
        tick();
        tick();
        chk("rst_ready",    64'(ia.ReqReady), 64'd0);
        chk("rst_busvalid", 64'(ia.BusValid), 64'd0);
        chk("rst_rspvalid", 64'(ia.RspValid), 64'd0);
        chk("rst_busaddr",  64'(ia.BusAddr),  64'd0);
        chk("rst_m_ready",  64'(im.ReqReady), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 64'(ia.ReqReady), 64'd1);

        // Store byte at 0x1003
        issue_a(1'b1, 2'd0, 1'b0, 32'h0000_1003, 32'h0000_00AB);
        chk("sb_valid", 64'(ia.BusValid), 64'd1);
        chk("sb_write", 64'(ia.BusWrite), 64'd1);
        chk("sb_addr",  64'(ia.BusAddr),  64'h1000);
        chk("sb_sel",   64'(ia.BusSel),   64'h8);
        chk("sb_data",  64'(ia.BusData),  64'hABAB_ABAB);
        chk("sb_rsp_early", 64'(ia.RspValid), 64'd0);
        tick();
        chk("sb_rsp",     64'(ia.RspValid), 64'd1);
        chk("sb_err",     64'(ia.RspErr),   64'd0);
        chk("sb_rspdata", 64'(ia.RspData),  64'd0);
        chk("sb_bus_off", 64'(ia.BusValid), 64'd0);
        tick();
        chk("sb_rsp_end", 64'(ia.RspValid), 64'd0);
        chk("sb_ready",   64'(ia.ReqReady), 64'd1);

        // Store half at 0x2002 with BusReady stalled for 3 cycles
        ia.BusReady = 1'b0;
        issue_a(1'b1, 2'd1, 1'b0, 32'h0000_2002, 32'h0000_1234);
        for (int k = 0; k < 3; k++) begin
            chk("sh_valid", 64'(ia.BusValid), 64'd1);
            chk("sh_addr",  64'(ia.BusAddr),  64'h2000);
            chk("sh_sel",   64'(ia.BusSel),   64'hC);
            chk("sh_data",  64'(ia.BusData),  64'h1234_1234);
            chk("sh_norsp", 64'(ia.RspValid), 64'd0);
            tick();
        end
        ia.BusReady = 1'b1;
        chk("sh_valid_rdy", 64'(ia.BusValid), 64'd1);
        chk("sh_data_rdy",  64'(ia.BusData),  64'h1234_1234);
        tick();
        chk("sh_rsp",     64'(ia.RspValid), 64'd1);
        chk("sh_bus_off", 64'(ia.BusValid), 64'd0);
        tick();
        chk("sh_rsp_end", 64'(ia.RspValid), 64'd0);

        // Load half signed at 0x3001
        issue_a(1'b0, 2'd1, 1'b1, 32'h0000_3001, 32'd0);
        chk("lhs_valid", 64'(ia.BusValid), 64'd1);
        chk("lhs_write", 64'(ia.BusWrite), 64'd0);
        chk("lhs_addr",  64'(ia.BusAddr),  64'h3000);
        chk("lhs_sel",   64'(ia.BusSel),   64'h6);
        tick();
        chk("lhs_wait", 64'(ia.BusValid), 64'd0);
        ia.BusRdValid = 1'b1;
        ia.BusRdData  = 32'h4480_0122;
        tick();
        ia.BusRdValid = 1'b0;
        chk("lhs_rsp",   64'(ia.RspValid), 64'd1);
        chk("lhs_data",  64'(ia.RspData),  64'hFFFF_8001);
        chk("lhs_err",   64'(ia.RspErr),   64'd0);
        chk("lhs_1beat", 64'(ia.BusValid), 64'd0);
        tick();

        // Same load, zero-extended
        issue_a(1'b0, 2'd1, 1'b0, 32'h0000_3001, 32'd0);
        tick();
        ia.BusRdValid = 1'b1;
        ia.BusRdData  = 32'h4480_0122;
        tick();
        ia.BusRdValid = 1'b0;
        chk("lhu_rsp",  64'(ia.RspValid), 64'd1);
        chk("lhu_data", 64'(ia.RspData),  64'h0000_8001);
        tick();

        // Split store word at 0x4002
        issue_a(1'b1, 2'd2, 1'b0, 32'h0000_4002, 32'hA1B2_C3D4);
        chk("sw_b0_addr", 64'(ia.BusAddr), 64'h4000);
        chk("sw_b0_sel",  64'(ia.BusSel),  64'hC);
        chk("sw_b0_data", 64'(ia.BusData), 64'hC3D4_A1B2);
        tick();
        chk("sw_b1_valid", 64'(ia.BusValid), 64'd1);
        chk("sw_b1_addr",  64'(ia.BusAddr),  64'h4004);
        chk("sw_b1_sel",   64'(ia.BusSel),   64'h3);
        chk("sw_b1_data",  64'(ia.BusData),  64'hC3D4_A1B2);
        chk("sw_norsp",    64'(ia.RspValid), 64'd0);
        tick();
        chk("sw_rsp",     64'(ia.RspValid), 64'd1);
        chk("sw_bus_off", 64'(ia.BusValid), 64'd0);
        tick();

        // Split load word at 0x5003; read data alongside the beat handshake is ignored
        issue_a(1'b0, 2'd2, 1'b0, 32'h0000_5003, 32'd0);
        chk("lw_b0_addr", 64'(ia.BusAddr), 64'h5000);
        chk("lw_b0_sel",  64'(ia.BusSel),  64'h8);
        ia.BusRdValid = 1'b1;
        ia.BusRdData  = 32'hDEAD_BEEF;
        tick();
        chk("lw_wait0", 64'(ia.BusValid), 64'd0);
        ia.BusRdData = 32'hEE00_0000;
        tick();
        ia.BusRdValid = 1'b0;
        chk("lw_b1_valid", 64'(ia.BusValid), 64'd1);
        chk("lw_b1_addr",  64'(ia.BusAddr),  64'h5004);
        chk("lw_b1_sel",   64'(ia.BusSel),   64'h7);
        tick();
        chk("lw_wait1", 64'(ia.BusValid), 64'd0);
        ia.BusRdValid = 1'b1;
        ia.BusRdData  = 32'h0033_2211;
        tick();
        ia.BusRdValid = 1'b0;
        chk("lw_rsp",  64'(ia.RspValid), 64'd1);
        chk("lw_data", 64'(ia.RspData),  64'h3322_11EE);
        tick();

        // Misaligned half on the strict instance is an error
        issue_m(1'b0, 2'd1, 1'b0, 32'h0000_6001, 32'd0);
        chk("mis_busvalid", 64'(im.BusValid), 64'd0);
        chk("mis_rsp",      64'(im.RspValid), 64'd1);
        chk("mis_err",      64'(im.RspErr),   64'd1);
        chk("mis_data",     64'(im.RspData),  64'd0);
        tick();
        chk("mis_rsp_end",  64'(im.RspValid), 64'd0);

        // Aligned word on the strict instance is serviced normally
        issue_m(1'b1, 2'd2, 1'b0, 32'h0000_6004, 32'h5566_7788);
        chk("m_sw_sel",  64'(im.BusSel),  64'hF);
        chk("m_sw_data", 64'(im.BusData), 64'h5566_7788);
        tick();
        chk("m_sw_err", 64'(im.RspErr), 64'd0);
        tick();

        // Dword on a 32-bit bus is an error
        issue_a(1'b0, 2'd3, 1'b0, 32'h0000_7000, 32'd0);
        chk("dw_busvalid", 64'(ia.BusValid), 64'd0);
        chk("dw_rsp",      64'(ia.RspValid), 64'd1);
        chk("dw_err",      64'(ia.RspErr),   64'd1);
        tick();

        // Reset while waiting for read data
        issue_a(1'b0, 2'd2, 1'b0, 32'h0000_8000, 32'd0);
        tick();
        chk("rw_wait0", 64'(ia.BusValid), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("rw_ready_low", 64'(ia.ReqReady), 64'd0);
        tick();
        chk("rw_busvalid", 64'(ia.BusValid), 64'd0);
        chk("rw_rspvalid", 64'(ia.RspValid), 64'd0);
        chk("rw_busaddr",  64'(ia.BusAddr),  64'd0);
        chk("rw_bussel",   64'(ia.BusSel),   64'd0);
        rst_n = 1'b1;
        ia.BusRdValid = 1'b1;
        ia.BusRdData  = 32'h1234_5678;
        tick();
        chk("rw_no_rsp", 64'(ia.RspValid), 64'd0);
        chk("rw_ready",  64'(ia.ReqReady), 64'd1);
        ia.BusRdValid = 1'b0;
        tick();
        chk("rw_no_rsp2", 64'(ia.RspValid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
